// File: rtl/rr_request_buffer_2ch.sv
// rr_request_buffer_2ch
//   Front end for a 2-request round-robin arbiter. There is one FIFO per
//   input channel. A FIFO that is not empty raises its request bit. The
//   arbiter's grant pops that FIFO into a single registered output stage,
//   which carries valid/ready handshaking and a source tag.
//
// Ports
//   clk        clock, all state updates on rising edge
//   rst        asynchronous active-high reset
//   in_valid   per-channel input word offered
//   in_ready   per-channel FIFO not full
//   in_data0/1 per-channel input word
//   requests   to arbiter: channel has a word and the output stage can load
//   grants     from arbiter: one-hot or zero
//   out_valid  output word valid
//   out_ready  downstream accepts output word
//   out_data   granted word
//   out_src    channel the word came from
//   err        sticky protocol error (illegal grant pattern)
module rr_request_buffer_2ch #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   in_valid,
   output logic [1:0]   in_ready,
   input  logic [W-1:0] in_data0,
   input  logic [W-1:0] in_data1,
   output logic [1:0]   requests,
   input  logic [1:0]   grants,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_src,
   output logic         err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [2][DEPTH];
   logic [AW-1:0] wr_ptr [2];
   logic [AW-1:0] rd_ptr [2];
   logic [CW-1:0] count [2];
   logic [W-1:0]  wr_data [2];
   logic [W-1:0]  head [2];
   logic [1:0]    empty;
   logic [1:0]    full;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic          can_load;
   logic          proto_err;

   always_comb begin
      wr_data[0] = in_data0;
      wr_data[1] = in_data1;
      empty      = 2'b00;
      full       = 2'b00;
      for (int i = 0; i < 2; i++) begin
         empty[i] = (count[i] == '0);
         full[i]  = (count[i] == FULL_CNT);
         head[i]  = mem[i][rd_ptr[i]];
      end
   end

   // in_ready depends only on the count, so a full FIFO refuses a push
   // even when the same edge pops it.
   assign in_ready  = ~full;
   assign push      = in_valid & in_ready;
   assign can_load  = !out_valid || out_ready;
   assign requests  = ~empty & {2{can_load}};

   // A double grant, or a grant without a matching request, is an error.
   // On that edge nothing is popped or loaded.
   assign proto_err = (grants == 2'b11) || ((grants & ~requests) != 2'b00);
   assign pop       = proto_err ? 2'b00 : (grants & requests);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CW'(1);
               2'b01:   count[i] <= count[i] - CW'(1);
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   // Storage has no reset. After reset the pointers are cleared, so any
   // old contents can no longer be read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= wr_data[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (pop[0]) begin
            out_valid <= 1'b1;
            out_data  <= head[0];
            out_src   <= 1'b0;
         end else if (pop[1]) begin
            out_valid <= 1'b1;
            out_data  <= head[1];
            out_src   <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (proto_err) err <= 1'b1;
      end
   end

endmodule
